fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR engine that feeds and consumes the FIR's two dual-port BRAMs.
- Accepts one input sample per valid/ready handshake and writes it into the sample delay-line BRAM at a circular write pointer.
- Then walks all TAPS taps, reading sample and coefficient BRAMs, and does one signed multiply-accumulate per cycle.
- Emits one filtered output per accepted sample: y[n] = sum over k of c[k]*x[n-k].

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_tap_addr_gen.sv | 85 ++++++++
 rtl/fir_mac_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR MAC sequencer:
//   - default sample / coefficient widths and filter length
//   - accumulator width derivation (wide enough that no sum can overflow)
//   - sequencer state encoding
// No ports; imported by fir_tap_addr_gen and fir_mac_sequencer.
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_TAPS   = 128;

    // A full-scale product needs DATA_W+COEF_W bits; summing TAPS of them
    // grows the result by at most $clog2(TAPS) bits.
    function automatic int accWidth(input int dataW, input int coefW, input int taps);
        return dataW + coefW + $clog2(taps);
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_e;

endpackage

// File: rtl/fir_tap_addr_gen.sv
// ---------------------------------------------------------------------------
// fir_tap_addr_gen
// Owns the circular write pointer and the tap counter k, and produces the
// registered BRAM read addresses for the tap walk.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   start_i        : load k=0 and sample address = wr_ptr (first tap)
//   step_i         : advance to the next tap (holds at the last tap)
//   advance_i      : move wr_ptr to the next delay-line slot
//   wr_ptr_o       : current write pointer (sample-BRAM write address)
//   smp_addr_o     : registered (wr_ptr - k) mod TAPS
//   coef_addr_o    : registered coefficient address (k)
//   last_tap_o     : k is the final tap, TAPS-1
// ---------------------------------------------------------------------------
module fir_tap_addr_gen
    import fir_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int ADDR_W = $clog2(TAPS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] smp_addr_o,
    output logic [ADDR_W-1:0] coef_addr_o,
    output logic              last_tap_o
);

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(TAPS - 1);
    // Truncates to zero when TAPS is a power of two, which is exactly the
    // wrap that modulo-2^ADDR_W arithmetic then supplies.
    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] smpAddr_q, smpAddr_d;

    // Next tap index, next write pointer and the circular read address of
    // the tap that k_d selects. The read address is computed from wr_ptr and
    // k with an explicit underflow test, so TAPS need not be a power of two.
    always_comb begin
        k_d       = k_q;
        wrPtr_d   = wrPtr_q;
        smpAddr_d = smpAddr_q;

        if (start_i) begin
            k_d = '0;
        end else if (step_i && (k_q != LAST_K)) begin
            k_d = k_q + ADDR_W'(1);
        end

        if (advance_i) begin
            wrPtr_d = (wrPtr_q == LAST_K) ? '0 : wrPtr_q + ADDR_W'(1);
        end

        if (start_i || step_i) begin
            if (wrPtr_q >= k_d) begin
                smpAddr_d = wrPtr_q - k_d;
            end else begin
                smpAddr_d = wrPtr_q + TAPS_A - k_d;
            end
        end
    end

    // Pointer, counter and address registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q   <= '0;
            k_q       <= '0;
            smpAddr_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            k_q       <= k_d;
            smpAddr_q <= smpAddr_d;
        end
    end

    assign wr_ptr_o    = wrPtr_q;
    assign smp_addr_o  = smpAddr_q;
    assign coef_addr_o = k_q;
    assign last_tap_o  = (k_q == LAST_K);

endmodule

// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
// Time-multiplexed FIR engine. Accepts one sample per handshake, writes it
// into the sample delay-line BRAM, then walks all TAPS taps doing one signed
// multiply-accumulate per cycle and emits y[n] = sum_k c[k]*x[n-k].
//   clk, i_rst                     : clock, asynchronous active-high reset
//   i_sample, i_sample_valid       : input sample and its valid
//   o_ready                        : high only while idle
//   o_smp_we/_addr_wr/_data        : sample-BRAM write port
//   o_smp_addr_rd, i_smp_rdata     : sample-BRAM read port (1-cycle read)
//   o_coef_addr_rd, i_coef_rdata   : coefficient-BRAM read port (1-cycle read)
//   o_result, o_result_valid       : filtered output and one-cycle strobe
// ---------------------------------------------------------------------------
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int ADDR_W = $clog2(TAPS),
    parameter int ACC_W  = accWidth(DATA_W, COEF_W, TAPS)
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_sample_valid,
    output logic              o_ready,
    output logic              o_smp_we,
    output logic [ADDR_W-1:0] o_smp_addr_wr,
    output logic [DATA_W-1:0] o_smp_data,
    output logic [ADDR_W-1:0] o_smp_addr_rd,
    input  logic [DATA_W-1:0] i_smp_rdata,
    output logic [ADDR_W-1:0] o_coef_addr_rd,
    input  logic [COEF_W-1:0] i_coef_rdata,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_result_valid
);

    localparam int PROD_W = DATA_W + COEF_W;

    state_e                    state_q, state_d;
    logic [1:0]                drainCnt_q, drainCnt_d;
    logic [DATA_W-1:0]         sample_q;
    logic                      rdValid_q;
    logic                      prodValid_q;
    logic signed [PROD_W-1:0]  product_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]          result_q;
    logic                      resultValid_q;

    logic accept;
    logic startWalk;
    logic stepTap;
    logic advancePtr;
    logic lastTap;

    fir_tap_addr_gen #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i       (clk),
        .rst_i       (i_rst),
        .start_i     (startWalk),
        .step_i      (stepTap),
        .advance_i   (advancePtr),
        .wr_ptr_o    (o_smp_addr_wr),
        .smp_addr_o  (o_smp_addr_rd),
        .coef_addr_o (o_coef_addr_rd),
        .last_tap_o  (lastTap)
    );

    // Sequencer next-state logic. The write cycle sits between accept and
    // the first read so that tap 0 sees the new sample rather than the stale
    // word (the BRAM returns old data on a same-cycle read/write). DRAIN
    // lasts three cycles to let the last address reach the accumulator.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        accept     = 1'b0;
        startWalk  = 1'b0;
        stepTap    = 1'b0;
        advancePtr = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_sample_valid) begin
                    accept  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                startWalk = 1'b1;
                state_d   = READ;
            end
            READ: begin
                stepTap = 1'b1;
                if (lastTap) begin
                    drainCnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (drainCnt_q == 2'd2) begin
                    state_d = OUT;
                end else begin
                    drainCnt_d = drainCnt_q + 2'd1;
                end
            end
            OUT: begin
                advancePtr = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    // MAC pipeline: an address presented during READ returns data one cycle
    // later, which is registered as a full-width signed product, which is
    // then sign-extended and added into the accumulator. The valid flags
    // follow the address through the same stages.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sample_q    <= '0;
            rdValid_q   <= 1'b0;
            prodValid_q <= 1'b0;
            product_q   <= '0;
            acc_q       <= '0;
        end else begin
            rdValid_q   <= (state_q == READ);
            prodValid_q <= rdValid_q;
            if (accept) begin
                sample_q <= i_sample;
            end
            if (rdValid_q) begin
                product_q <= PROD_W'($signed(i_smp_rdata)) * PROD_W'($signed(i_coef_rdata));
            end
            if (accept) begin
                acc_q <= '0;
            end else if (prodValid_q) begin
                acc_q <= acc_q + ACC_W'(product_q);
            end
        end
    end

    // Output register: the result holds between strobes.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            result_q      <= '0;
            resultValid_q <= 1'b0;
        end else begin
            resultValid_q <= (state_q == OUT);
            if (state_q == OUT) begin
                result_q <= acc_q;
            end
        end
    end

    assign o_ready        = (state_q == IDLE);
    assign o_smp_we       = (state_q == WRITE);
    assign o_smp_data     = sample_q;
    assign o_result       = result_q;
    assign o_result_valid = resultValid_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_sequencer
// Bench for fir_mac_sequencer with TAPS=4, behavioural 1-cycle-read BRAMs
// and a delay-line reference model of y[n] = sum_k c[k]*x[n-k].
// ---------------------------------------------------------------------------
module tb_fir_mac_sequencer;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 4;
    localparam int ADDR_W = 2;
    localparam int ACC_W  = 34;
    localparam int LAT    = TAPS + 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic              ready;
    logic              smpWe;
    logic [ADDR_W-1:0] smpAddrWr;
    logic [DATA_W-1:0] smpData;
    logic [ADDR_W-1:0] smpAddrRd;
    logic [DATA_W-1:0] smpRdata;
    logic [ADDR_W-1:0] coefAddrRd;
    logic [COEF_W-1:0] coefRdata;
    logic [ACC_W-1:0]  result;
    logic              resultValid;

    logic [DATA_W-1:0] smpMem [TAPS] = '{default: '0};
    logic [COEF_W-1:0] coefMem [TAPS];

    int checks = 0;
    int errors = 0;

    // Reference model: the delay line as an array indexed by write slot.
    longint lineM [TAPS] = '{default: 0};
    int     ptrM = 0;

    fir_mac_sequencer #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk            (clk),
        .i_rst          (rst),
        .i_sample       (sample),
        .i_sample_valid (valid),
        .o_ready        (ready),
        .o_smp_we       (smpWe),
        .o_smp_addr_wr  (smpAddrWr),
        .o_smp_data     (smpData),
        .o_smp_addr_rd  (smpAddrRd),
        .i_smp_rdata    (smpRdata),
        .o_coef_addr_rd (coefAddrRd),
        .i_coef_rdata   (coefRdata),
        .o_result       (result),
        .o_result_valid (resultValid)
    );

    always #5 clk = ~clk;

    // Behavioural BRAMs: registered read, a same-cycle read returns old data.
    always @(posedge clk) begin
        if (smpWe) smpMem[smpAddrWr] <= smpData;
        smpRdata  <= smpMem[smpAddrRd];
        coefRdata <= coefMem[coefAddrRd];
    end

    task automatic setCoefs(input int c0, input int c1, input int c2, input int c3);
        coefMem[0] = 16'(c0);
        coefMem[1] = 16'(c1);
        coefMem[2] = 16'(c2);
        coefMem[3] = 16'(c3);
    endtask

    task automatic modelPush(input int x, output longint y);
        lineM[ptrM] = longint'(x);
        y = 0;
        for (int k = 0; k < TAPS; k++) begin
            y += longint'($signed(coefMem[k])) * lineM[(ptrM - k + TAPS) % TAPS];
        end
        ptrM = (ptrM + 1) % TAPS;
    endtask

    // Offers one sample and observes the transaction. n=0 is the cycle right
    // after the accept edge; the strobe is expected at n=LAT.
    task automatic runSample(input int x, output bit accepted, output bit weSeen,
                             output int wrAddr, output int wrData, output int latency,
                             output bit readyLow, output logic [ACC_W-1:0] got);
        int waitCnt;
        accepted = 1'b0; weSeen = 1'b0; wrAddr = -1; wrData = 0;
        latency = -1; readyLow = 1'b1; got = '0;
        @(negedge clk);
        sample = 16'(x);
        valid  = 1'b1;
        waitCnt = 0;
        while (!ready && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!ready) begin
            valid = 1'b0;
            return;
        end
        accepted = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                valid  = 1'b0;
                sample = '0;
                weSeen = smpWe;
                wrAddr = int'(smpAddrWr);
                wrData = int'($signed(smpData));
            end
            if (resultValid) begin
                latency = n;
                got     = result;
                break;
            end
            if (ready) readyLow = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0; sample = '0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        checks++; if (smpWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", smpWe); end
        checks++; if (smpAddrWr !== '0 || smpAddrRd !== '0 || coefAddrRd !== '0) begin
            errors++; $display("[TB] FAIL reset_addr got wr=%0d rd=%0d coef=%0d want 0", smpAddrWr, smpAddrRd, coefAddrRd); end
        checks++; if (smpData !== '0) begin errors++; $display("[TB] FAIL reset_data got %0d want 0", smpData); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result got %0d want 0", result); end
        checks++; if (resultValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", resultValid); end
        rst = 1'b0;
        ptrM = 0;
        @(negedge clk);
        checks++; if (ready !== 1'b1 || resultValid !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_idle got ready=%b valid=%b want 1/0", ready, resultValid); end
    endtask

    task automatic test_impulse;
        int vals [5] = '{100, 0, 0, 0, 0};
        int expPtr, wrAddr, wrData, latency;
        bit acc, we, rl;
        longint expY;
        logic [ACC_W-1:0] got, lastGot;
        setCoefs(1, 2, 3, 4);
        lastGot = '0;
        for (int i = 0; i < 5; i++) begin
            expPtr = ptrM;
            modelPush(vals[i], expY);
            runSample(vals[i], acc, we, wrAddr, wrData, latency, rl, got);
            checks++; if (!acc) begin errors++; $display("[TB] FAIL impulse_accept[%0d] got 0 want 1", i); end
            checks++; if (!we || wrAddr != expPtr || wrData != vals[i]) begin
                errors++; $display("[TB] FAIL impulse_write[%0d] got we=%b addr=%0d data=%0d want 1/%0d/%0d", i, we, wrAddr, wrData, expPtr, vals[i]); end
            checks++; if (latency != LAT || !rl) begin
                errors++; $display("[TB] FAIL impulse_latency[%0d] got %0d readyLow=%b want %0d/1", i, latency, rl, LAT); end
            checks++; if (got !== ACC_W'(expY)) begin
                errors++; $display("[TB] FAIL impulse_result[%0d] got %0d want %0d", i, $signed(got), expY); end
            lastGot = got;
        end
        @(negedge clk);
        checks++; if (resultValid !== 1'b0 || result !== lastGot) begin
            errors++; $display("[TB] FAIL result_hold got valid=%b result=%0d want 0/%0d", resultValid, $signed(result), $signed(lastGot)); end
    endtask

    task automatic test_step_wrap;
        int expPtr, wrAddr, wrData, latency;
        bit acc, we, rl;
        longint expY;
        logic [ACC_W-1:0] got;
        for (int i = 0; i < 6; i++) begin
            expPtr = ptrM;
            modelPush(10, expY);
            runSample(10, acc, we, wrAddr, wrData, latency, rl, got);
            checks++; if (!acc || !we || wrAddr != expPtr || wrData != 10) begin
                errors++; $display("[TB] FAIL step_write[%0d] got acc=%b we=%b addr=%0d want 1/1/%0d", i, acc, we, wrAddr, expPtr); end
            checks++; if (latency != LAT) begin
                errors++; $display("[TB] FAIL step_latency[%0d] got %0d want %0d", i, latency, LAT); end
            checks++; if (got !== ACC_W'(expY)) begin
                errors++; $display("[TB] FAIL step_result[%0d] got %0d want %0d", i, $signed(got), expY); end
        end
    endtask

    task automatic test_extremes;
        int wrAddr, wrData, latency;
        bit acc, we, rl;
        longint expY;
        logic [ACC_W-1:0] got;
        setCoefs(-32768, -32768, -32768, -32768);
        for (int i = 0; i < 4; i++) begin
            modelPush(-32768, expY);
            runSample(-32768, acc, we, wrAddr, wrData, latency, rl, got);
            checks++; if (!acc || latency != LAT || got !== ACC_W'(expY)) begin
                errors++; $display("[TB] FAIL extreme_result[%0d] got %0d lat=%0d want %0d lat=%0d", i, $signed(got), latency, expY, LAT); end
        end
        checks++; if (got !== 34'h1_0000_0000) begin
            errors++; $display("[TB] FAIL extreme_full_scale got %0d want 4294967296", $signed(got)); end
    endtask

    task automatic test_back_to_back;
        int     vals [3] = '{1, 2, 3};
        int     accCyc [$];
        longint expQ [$];
        int     idx, strobes;
        bit     pend;
        longint expY;
        setCoefs(1, 2, 3, 4);
        @(negedge clk);
        idx = 0; strobes = 0; pend = 1'b0;
        sample = 16'(vals[0]);
        valid  = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 3) sample = 16'(vals[idx]);
                else begin valid = 1'b0; sample = '0; end
            end
            if (resultValid) begin
                strobes++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL b2b_extra_strobe got %0d want none", $signed(result));
                end else if (result !== ACC_W'(expQ[0])) begin
                    errors++; $display("[TB] FAIL b2b_result got %0d want %0d", $signed(result), expQ[0]);
                end
                if (expQ.size() > 0) void'(expQ.pop_front());
            end
            if (ready && valid) begin
                accCyc.push_back(cyc);
                modelPush(vals[idx], expY);
                expQ.push_back(expY);
                pend = 1'b1;
            end
        end
        valid = 1'b0;
        checks++; if (accCyc.size() != 3 || strobes != 3) begin
            errors++; $display("[TB] FAIL b2b_counts got accepts=%0d strobes=%0d want 3/3", accCyc.size(), strobes); end
        if (accCyc.size() == 3) begin
            checks++; if (accCyc[1] - accCyc[0] != TAPS + 6 || accCyc[2] - accCyc[1] != TAPS + 6) begin
                errors++; $display("[TB] FAIL b2b_spacing got %0d,%0d want %0d", accCyc[1] - accCyc[0], accCyc[2] - accCyc[1], TAPS + 6); end
        end
    endtask

    task automatic test_reset_mid_read;
        int oldPtr, wrAddr, wrData, latency;
        bit seen, acc, we, rl;
        longint expY;
        logic [ACC_W-1:0] got;
        setCoefs(1, 2, 3, 4);
        @(negedge clk);
        sample = 16'(50);
        valid  = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", ready); end
        oldPtr = ptrM;
        @(posedge clk);
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            if (n == 0) begin valid = 1'b0; sample = '0; end
        end
        checks++; if (int'(coefAddrRd) != 2 || int'(smpAddrRd) != (oldPtr - 2 + TAPS) % TAPS) begin
            errors++; $display("[TB] FAIL midrst_tap2_addr got coef=%0d smp=%0d want 2/%0d", coefAddrRd, smpAddrRd, (oldPtr - 2 + TAPS) % TAPS); end
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1 || smpWe !== 1'b0 || smpAddrWr !== '0 || smpAddrRd !== '0 ||
                      coefAddrRd !== '0 || smpData !== '0 || result !== '0 || resultValid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_outputs got rdy=%b we=%b wa=%0d ra=%0d ca=%0d d=%0d r=%0d v=%b want reset values",
                               ready, smpWe, smpAddrWr, smpAddrRd, coefAddrRd, smpData, result, resultValid); end
        lineM[oldPtr] = 50;
        ptrM = 0;
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 1) rst = 1'b0;
            if (resultValid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL midrst_no_strobe got strobe want none"); end
        modelPush(7, expY);
        runSample(7, acc, we, wrAddr, wrData, latency, rl, got);
        checks++; if (!acc || !we || wrAddr != 0 || wrData != 7) begin
            errors++; $display("[TB] FAIL midrst_next_write got we=%b addr=%0d data=%0d want 1/0/7", we, wrAddr, wrData); end
        checks++; if (latency != LAT || got !== ACC_W'(expY)) begin
            errors++; $display("[TB] FAIL midrst_next_result got %0d lat=%0d want %0d lat=%0d", $signed(got), latency, expY, LAT); end
    endtask

    task automatic test_collision;
        int wrAddr, wrData, latency;
        bit acc, we, rl;
        longint expY;
        logic [ACC_W-1:0] got;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptrM = 0;
        setCoefs(1, 0, 0, 0);
        modelPush(5, expY);
        runSample(5, acc, we, wrAddr, wrData, latency, rl, got);
        checks++; if (!acc || wrAddr != 0) begin
            errors++; $display("[TB] FAIL collision_write got acc=%b addr=%0d want 1/0", acc, wrAddr); end
        checks++; if (got !== ACC_W'(expY) || got !== 34'd5) begin
            errors++; $display("[TB] FAIL collision_result got %0d want 5", $signed(got)); end
    endtask

    task automatic test_random;
        int x, wrAddr, wrData, latency;
        bit acc, we, rl;
        longint expY;
        logic [ACC_W-1:0] got;
        for (int k = 0; k < TAPS; k++) coefMem[k] = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
            x = int'($signed(16'($urandom)));
            modelPush(x, expY);
            runSample(x, acc, we, wrAddr, wrData, latency, rl, got);
            checks++; if (!acc || latency != LAT || got !== ACC_W'(expY)) begin
                errors++; $display("[TB] FAIL random_result[%0d] got %0d lat=%0d want %0d lat=%0d", i, $signed(got), latency, expY, LAT); end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        sample = '0;
        setCoefs(1, 2, 3, 4);
        $display("[TB] starting fir_mac_sequencer bench");
        test_reset();
        test_impulse();
        test_step_wrap();
        test_extremes();
        test_back_to_back();
        test_reset_mid_read();
        test_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
